// File: rtl/fifo_pkg.sv
// Shared definitions for the stream FIFO family: default payload and depth
// constants used across the butterfly stages, and a width helper.
package fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int DEFAULT_DEPTH      = 16;

  // Index width for an array of the given depth; never below one bit.
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/stream_fifo_if.sv
// Valid/ready stream, control and status signals of one stream_fifo instance.
// slave is the FIFO side, master is the producer/consumer/control side.
interface stream_fifo_if
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH
);
  localparam int ADDR_W = addr_width(DEPTH);

  logic                  flush;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [ADDR_W:0]       count;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_W:0]       high_water;
  logic                  hw_clear;

  modport slave (
    input  flush, in_valid, in_data, out_ready, hw_clear,
    output in_ready, out_valid, out_data, count, almost_full, almost_empty, high_water
  );

  modport master (
    output flush, in_valid, in_data, out_ready, hw_clear,
    input  in_ready, out_valid, out_data, count, almost_full, almost_empty, high_water
  );

endinterface

// File: rtl/fifo_mem.sv
// Simple dual-port register array: synchronous write, combinational read.
// Contents are intentionally not reset.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int ADDR_W     = addr_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/stream_fifo.sv
// First-word-fall-through stream FIFO with occupancy count, almost flags,
// synchronous flush and a high-water occupancy monitor.
module stream_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int DEPTH         = DEFAULT_DEPTH,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic          clk,
  input  logic          rst,
  stream_fifo_if.slave  bus
);

  localparam int              ADDR_W   = addr_width(DEPTH);
  localparam logic [ADDR_W:0] ONE_C    = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] AFULL_C  = (ADDR_W + 1)'(AFULL_THRESH);
  localparam logic [ADDR_W:0] AEMPTY_C = (ADDR_W + 1)'(AEMPTY_THRESH);

  if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_err
    $error("stream_fifo: DEPTH must be a power of two and at least 4");
  end
  if ((AFULL_THRESH < 1) || (AFULL_THRESH > DEPTH)) begin : g_afull_err
    $error("stream_fifo: AFULL_THRESH must lie in 1..DEPTH");
  end
  if ((AEMPTY_THRESH < 0) || (AEMPTY_THRESH > DEPTH - 1)) begin : g_aempty_err
    $error("stream_fifo: AEMPTY_THRESH must lie in 0..DEPTH-1");
  end

  logic [ADDR_W:0]       wr_ptr_r, rd_ptr_r, count_r, high_water_r;
  logic [ADDR_W:0]       wr_ptr_nxt_s, rd_ptr_nxt_s, count_nxt_s, high_water_nxt_s;
  logic                  empty_s, full_s, push_s, pop_s, mem_we_s;
  logic [DATA_WIDTH-1:0] rdata_s;

  // The MSB of each pointer is the wrap bit separating full from empty.
  assign empty_s  = (wr_ptr_r == rd_ptr_r);
  assign full_s   = (wr_ptr_r[ADDR_W-1:0] == rd_ptr_r[ADDR_W-1:0]) &&
                    (wr_ptr_r[ADDR_W] != rd_ptr_r[ADDR_W]);
  assign push_s   = bus.in_valid & ~full_s;
  assign pop_s    = bus.out_ready & ~empty_s;
  assign mem_we_s = push_s & ~bus.flush;

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_W     (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we_s),
    .waddr (wr_ptr_r[ADDR_W-1:0]),
    .wdata (bus.in_data),
    .raddr (rd_ptr_r[ADDR_W-1:0]),
    .rdata (rdata_s)
  );

  // Next pointer and occupancy; flush overrides any handshake in the same cycle
  always_comb begin
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    count_nxt_s  = count_r;
    if (bus.flush) begin
      wr_ptr_nxt_s = '0;
      rd_ptr_nxt_s = '0;
      count_nxt_s  = '0;
    end else begin
      if (push_s) begin
        wr_ptr_nxt_s = wr_ptr_r + ONE_C;
      end else begin
        wr_ptr_nxt_s = wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_nxt_s = rd_ptr_r + ONE_C;
      end else begin
        rd_ptr_nxt_s = rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_nxt_s = count_r + ONE_C;
        2'b01:   count_nxt_s = count_r - ONE_C;
        default: count_nxt_s = count_r;
      endcase
    end
  end

  // High-water tracks the next occupancy so a clear restarts from the live value
  always_comb begin
    high_water_nxt_s = high_water_r;
    if (bus.hw_clear) begin
      high_water_nxt_s = count_nxt_s;
    end else if (count_nxt_s > high_water_r) begin
      high_water_nxt_s = count_nxt_s;
    end else begin
      high_water_nxt_s = high_water_r;
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r     <= '0;
      rd_ptr_r     <= '0;
      count_r      <= '0;
      high_water_r <= '0;
    end else begin
      wr_ptr_r     <= wr_ptr_nxt_s;
      rd_ptr_r     <= rd_ptr_nxt_s;
      count_r      <= count_nxt_s;
      high_water_r <= high_water_nxt_s;
    end
  end

  assign bus.in_ready     = ~full_s;
  assign bus.out_valid    = ~empty_s;
  assign bus.out_data     = empty_s ? '0 : rdata_s;
  assign bus.count        = count_r;
  assign bus.almost_full  = (count_r >= AFULL_C);
  assign bus.almost_empty = (count_r <= AEMPTY_C);
  assign bus.high_water   = high_water_r;

endmodule
